// File: rtl/cpu_pkg.sv
// Shared opcode indices, sequencer state type and break-flag bit positions
// for the instruction sequencer and its opcode decoder.
package cpu_pkg;

  localparam int OPC_W   = 5;
  localparam int NUM_OPS = 27;

  localparam int OP_LOADI_LOADP = 6;
  localparam int OP_ADD         = 7;
  localparam int OP_STORE       = 13;
  localparam int OP_BRE_BRZ     = 19;
  localparam int OP_BRNE_BRNZ   = 20;
  localparam int OP_BRG         = 21;
  localparam int OP_BRGE        = 22;

  localparam int BRK_B4 = 3;  // BRE_BRZ   : Z
  localparam int BRK_B3 = 2;  // BRNE_BRNZ : ~Z
  localparam int BRK_B2 = 1;  // BRG       : G & ~Z
  localparam int BRK_B1 = 0;  // BRGE      : G | Z

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2
  } seq_state_t;

  function automatic logic is_mem_op(input logic [OPC_W-1:0] opc);
    return (opc == OPC_W'(OP_LOADI_LOADP)) || (opc == OPC_W'(OP_STORE));
  endfunction

endpackage

// File: rtl/opcode_onehot_dec.sv
// Combinational binary-to-one-hot opcode decoder; codes at or above NUM
// decode to all-zero and raise illegal_o.
module opcode_onehot_dec
  import cpu_pkg::*;
#(
  parameter int NUM = NUM_OPS
) (
  input  logic [OPC_W-1:0] opc_i,
  output logic [NUM-1:0]   onehot_o,
  output logic             illegal_o
);

  for (genvar gi = 0; gi < NUM; gi++) begin : g_bit
    assign onehot_o[gi] = (opc_i == OPC_W'(gi));
  end

  // Widened compare so a NUM equal to 2**OPC_W does not wrap to zero.
  assign illegal_o = ({1'b0, opc_i} >= (OPC_W + 1)'(NUM));

endmodule

// File: rtl/opcode_sequencer.sv
// Instruction-side sequencer: FETCH/DECODE/EXEC handshake, one-hot opcode
// issue, memory-op hold with timeout, and ALU flag tracking for break_flag.
module opcode_sequencer
  import cpu_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int MEM_TO  = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [INSTR_W-1:0]       instr_word,
  input  logic                     mem_done,
  input  logic                     flags_we,
  input  logic                     alu_zero,
  input  logic                     alu_gt,
  output logic [NUM_OPS-1:0]       opcode_out,
  output logic [3:0]               break_flag,
  output logic [INSTR_W-OPC_W-1:0] operand,
  output logic                     exec_valid,
  output logic                     illegal_op,
  output logic                     mem_timeout
);

  localparam int OPND_W = INSTR_W - OPC_W;
  localparam int CNT_W  = $clog2(MEM_TO + 1);

  seq_state_t         state_q;
  logic [OPC_W-1:0]   opc_q;
  logic [OPND_W-1:0]  operand_q;
  logic [NUM_OPS-1:0] opcode_q;
  logic               exec_q;
  logic               illegal_q;
  logic               is_mem_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [3:0]         break_q;
  logic [3:0]         break_d;

  logic [NUM_OPS-1:0] dec_onehot;
  logic               dec_illegal;
  logic               at_limit;
  logic               last_exec;

  opcode_onehot_dec #(
    .NUM (NUM_OPS)
  ) u_dec (
    .opc_i     (opc_q),
    .onehot_o  (dec_onehot),
    .illegal_o (dec_illegal)
  );

  always_comb begin
    break_d         = '0;
    break_d[BRK_B4] = alu_zero;
    break_d[BRK_B3] = ~alu_zero;
    break_d[BRK_B2] = alu_gt & ~alu_zero;
    break_d[BRK_B1] = alu_gt | alu_zero;
  end

  assign at_limit  = (cnt_q == CNT_W'(MEM_TO));
  assign last_exec = !is_mem_q || mem_done || at_limit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      opc_q     <= '0;
      operand_q <= '0;
      opcode_q  <= '0;
      exec_q    <= 1'b0;
      illegal_q <= 1'b0;
      is_mem_q  <= 1'b0;
      cnt_q     <= '0;
      break_q   <= 4'b0000;
    end else begin
      illegal_q <= 1'b0;
      case (state_q)
        FETCH: begin
          if (instr_valid) begin
            opc_q     <= instr_word[INSTR_W-1 -: OPC_W];
            operand_q <= instr_word[OPND_W-1:0];
            state_q   <= DECODE;
          end
        end
        DECODE: begin
          if (dec_illegal) begin
            illegal_q <= 1'b1;
            state_q   <= FETCH;
          end else begin
            opcode_q <= dec_onehot;
            exec_q   <= 1'b1;
            is_mem_q <= is_mem_op(opc_q);
            cnt_q    <= CNT_W'(1);
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          // Flags and break_flag are only written from EXEC; reset clears
          // break_q, which doubles as the "no flags captured yet" state.
          if (flags_we) begin
            break_q <= break_d;
          end
          if (last_exec) begin
            opcode_q <= '0;
            exec_q   <= 1'b0;
            is_mem_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= FETCH;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign instr_ready = (state_q == FETCH);
  assign opcode_out  = opcode_q;
  assign operand     = operand_q;
  assign exec_valid  = exec_q;
  assign illegal_op  = illegal_q;
  assign break_flag  = break_q;
  // Depends on mem_done in the same cycle: a completion on the final
  // permitted cycle is a normal finish, not a timeout.
  assign mem_timeout = exec_q && is_mem_q && at_limit && !mem_done;

endmodule

// File: tb/tb_opcode_sequencer.sv
// Self-checking bench for opcode_sequencer: table of instructions with
// expected results fed through a scoreboard, plus reset sequences.
module tb_opcode_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_word;
  logic        mem_done;
  logic        flags_we;
  logic        alu_zero;
  logic        alu_gt;
  logic [26:0] opcode_out;
  logic [3:0]  break_flag;
  logic [10:0] operand;
  logic        exec_valid;
  logic        illegal_op;
  logic        mem_timeout;

  always #5 clk = ~clk;

  opcode_sequencer #(
    .INSTR_W (16),
    .MEM_TO  (15)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_word  (instr_word),
    .mem_done    (mem_done),
    .flags_we    (flags_we),
    .alu_zero    (alu_zero),
    .alu_gt      (alu_gt),
    .opcode_out  (opcode_out),
    .break_flag  (break_flag),
    .operand     (operand),
    .exec_valid  (exec_valid),
    .illegal_op  (illegal_op),
    .mem_timeout (mem_timeout)
  );

  typedef struct {
    logic [15:0] word;
    logic        fwe;
    logic        az;
    logic        ag;
    int          done_n;
    logic [26:0] opc;
    logic [10:0] opnd;
    int          cycles;
    logic        timeout;
    logic        illegal;
    logic [3:0]  brk;
  } vec_t;

  localparam int NV = 12;
  vec_t vt [NV];
  vec_t sb [$];

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] word, input logic fwe, input logic az,
                              input logic ag, input int done_n, input logic [26:0] opc,
                              input logic [10:0] opnd, input int cycles, input logic timeout,
                              input logic illegal, input logic [3:0] brk);
    vec_t v;
    v.word = word; v.fwe = fwe; v.az = az; v.ag = ag; v.done_n = done_n;
    v.opc = opc; v.opnd = opnd; v.cycles = cycles; v.timeout = timeout;
    v.illegal = illegal; v.brk = brk;
    return v;
  endfunction

  // Monitor: collects one transaction per EXEC run (or illegal pulse) and
  // compares it against the head of the scoreboard.
  logic [26:0] cap_opc;
  logic [10:0] cap_opnd;
  int          run, to_cnt, to_at, txn;
  bit          stable_err, zero_err;
  vec_t        e;

  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      run = 0; to_cnt = 0; to_at = 0; stable_err = 0; zero_err = 0;
      cap_opc = '0; cap_opnd = '0;
    end else if (exec_valid) begin
      if (run == 0) begin
        cap_opc  = opcode_out;
        cap_opnd = operand;
      end else if (opcode_out !== cap_opc || operand !== cap_opnd) begin
        stable_err = 1;
      end
      if (!$onehot(opcode_out) || illegal_op) stable_err = 1;
      run++;
      if (mem_timeout) begin
        to_cnt++;
        to_at = run;
      end
    end else begin
      if (opcode_out !== '0 || mem_timeout) zero_err = 1;
      if (run > 0 || illegal_op) begin
        if (run == 0) cap_opnd = operand;
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk($sformatf("t%0d_opcode", txn), {5'd0, cap_opc}, {5'd0, e.opc});
          chk($sformatf("t%0d_operand", txn), {21'd0, cap_opnd}, {21'd0, e.opnd});
          chk($sformatf("t%0d_exec_cycles", txn), run, e.cycles);
          chk($sformatf("t%0d_timeout_pulses", txn), to_cnt, {31'd0, e.timeout});
          if (e.timeout) chk($sformatf("t%0d_timeout_pos", txn), to_at, e.cycles);
          chk($sformatf("t%0d_illegal", txn), {31'd0, illegal_op}, {31'd0, e.illegal});
          chk($sformatf("t%0d_break_flag", txn), {28'd0, break_flag}, {28'd0, e.brk});
          chk($sformatf("t%0d_stable_onehot", txn), {31'd0, stable_err}, 32'd0);
          chk($sformatf("t%0d_zero_outside_exec", txn), {31'd0, zero_err}, 32'd0);
        end
        $display("txn %0d word=%h opc=%h operand=%h cycles=%0d timeouts=%0d illegal=%0b break=%b",
                 txn, e.word, cap_opc, cap_opnd, run, to_cnt, illegal_op, break_flag);
        txn++;
        run = 0; to_cnt = 0; to_at = 0; stable_err = 0; zero_err = 0; cap_opc = '0;
      end
    end
  end

  task automatic run_vec(input int idx, input vec_t v);
    bit got;
    int k;
    got = 0;
    for (int w = 0; w < 50 && !got; w++) begin
      @(negedge clk);
      if (instr_ready) got = 1;
    end
    chk($sformatf("v%0d_ready_wait", idx), {31'd0, got}, 32'd1);
    instr_word  = v.word;
    instr_valid = 1'b1;
    flags_we    = v.fwe;
    alu_zero    = v.az;
    alu_gt      = v.ag;
    sb.push_back(v);
    @(negedge clk);
    instr_valid = 1'b0;
    instr_word  = 16'hFFFF;
    got = 0;
    k   = 0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (instr_ready) begin
        got = 1;
        k   = c;
      end else begin
        mem_done = (c == v.done_n);
      end
    end
    mem_done = 1'b0;
    chk($sformatf("v%0d_ready_latency", idx), k, v.cycles + 1);
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr_word = '0; mem_done = 1'b0;
    flags_we = 1'b0; alu_zero = 1'b0; alu_gt = 1'b0; txn = 0;

    //         word     fwe z  g  done opcode        operand cyc to ill break
    vt[0]  = mk(16'h3805, 0, 0, 0, 0,  27'h0000080, 11'h005, 1,  0, 0, 4'b0000);
    vt[1]  = mk(16'h3805, 1, 1, 0, 0,  27'h0000080, 11'h005, 1,  0, 0, 4'b1001);
    vt[2]  = mk(16'h3AAA, 1, 0, 1, 0,  27'h0000080, 11'h2AA, 1,  0, 0, 4'b0111);
    vt[3]  = mk(16'hD800, 1, 1, 1, 0,  27'h0000000, 11'h000, 0,  0, 1, 4'b0111);
    vt[4]  = mk(16'h6800, 1, 1, 1, 3,  27'h0002000, 11'h000, 3,  0, 0, 4'b1001);
    vt[5]  = mk(16'h3000, 0, 0, 0, 0,  27'h0000040, 11'h000, 15, 1, 0, 4'b1001);
    vt[6]  = mk(16'h3123, 0, 0, 0, 1,  27'h0000040, 11'h123, 1,  0, 0, 4'b1001);
    vt[7]  = mk(16'h6FFF, 0, 0, 0, 15, 27'h0002000, 11'h7FF, 15, 0, 0, 4'b1001);
    vt[8]  = mk(16'hFFFF, 1, 0, 0, 0,  27'h0000000, 11'h7FF, 0,  0, 1, 4'b1001);
    vt[9]  = mk(16'hD00F, 1, 0, 0, 1,  27'h4000000, 11'h00F, 1,  0, 0, 4'b0100);
    vt[10] = mk(16'h0001, 0, 1, 1, 0,  27'h0000001, 11'h001, 1,  0, 0, 4'b0100);
    vt[11] = mk(16'h9800, 1, 1, 1, 0,  27'h0080000, 11'h000, 1,  0, 0, 4'b1001);

    repeat (3) @(negedge clk);
    chk("rst_exec_valid", {31'd0, exec_valid}, 32'd0);
    chk("rst_opcode_out", {5'd0, opcode_out}, 32'd0);
    chk("rst_operand", {21'd0, operand}, 32'd0);
    chk("rst_illegal", {31'd0, illegal_op}, 32'd0);
    chk("rst_timeout", {31'd0, mem_timeout}, 32'd0);
    chk("rst_break", {28'd0, break_flag}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", {31'd0, instr_ready}, 32'd1);
    mon_en = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(i, vt[i]);
    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    mon_en = 1'b0;

    // Reset in the middle of a STORE hold.
    flags_we = 1'b0;
    instr_word = 16'h6800; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("mid_exec1_valid", {31'd0, exec_valid}, 32'd1);
    @(negedge clk);
    chk("mid_exec2_opcode", {5'd0, opcode_out}, 32'h0002000);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_exec_valid", {31'd0, exec_valid}, 32'd0);
    chk("mid_rst_opcode", {5'd0, opcode_out}, 32'd0);
    chk("mid_rst_break", {28'd0, break_flag}, 32'd0);
    chk("mid_rst_operand", {21'd0, operand}, 32'd0);
    chk("mid_rst_timeout", {31'd0, mem_timeout}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_release_ready", {31'd0, instr_ready}, 32'd1);
    @(negedge clk);
    chk("mid_no_resume", {31'd0, exec_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
